// File: rtl/rca_pkg.sv
// Shared definitions for the sequential ripple-carry adder: FSM states and
// default slice geometry.
package rca_pkg;

  localparam int N_DEF = 4;
  localparam int M_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width: ceil(log2(M)), never less than one bit.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Request/result bundle of rca_seq_ctrl. Optional ovf flag present only when
// RCA_SEQ_OVF_EN is defined.
interface rca_seq_ctrl_if
  import rca_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) ();

  localparam int W = N * M;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         cout;
`ifdef RCA_SEQ_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef RCA_SEQ_OVF_EN
    input  ovf,
`endif
    input  busy, done, y, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef RCA_SEQ_OVF_EN
    output ovf,
`endif
    output busy, done, y, cout
  );

endinterface

// File: rtl/add_slice.sv
// Combinational N-bit adder slice with carry in/out; the only adder hardware
// in the sequential datapath.
module add_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] y,
  output logic         cout
);

  assign {cout, y} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential adder: one add_slice reused over M cycles, LSB slice first.
// Define RCA_SEQ_OVF_EN to add the two's-complement overflow output.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  rca_seq_ctrl_if.slave bus
);

  localparam int W     = N * M;
  localparam int IDX_W = idx_width(M);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_l;
  logic [W-1:0]       b_l;
  logic [W-1:0]       y_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;
`ifdef RCA_SEQ_OVF_EN
  logic               ovf_r;
`endif

  logic [N-1:0]       a_s;
  logic [N-1:0]       b_s;
  logic [N-1:0]       s_y;
  logic               s_co;
  logic               last;

  assign a_s  = a_l[int'(idx)*N +: N];
  assign b_s  = b_l[int'(idx)*N +: N];
  assign last = (idx == IDX_W'(M - 1));

  add_slice #(.N(N)) u_slice (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry),
    .y    (s_y),
    .cout (s_co)
  );

  // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_l    <= '0;
      b_l    <= '0;
      y_r    <= '0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_l    <= bus.a;
            b_l    <= bus.b;
            carry  <= bus.cin;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          y_r[int'(idx)*N +: N] <= s_y;
          carry                 <= s_co;
          if (last) begin
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            cout_r <= s_co;
`ifdef RCA_SEQ_OVF_EN
            // s_y[N-1] is the final y[W-1] being written on this edge.
            ovf_r  <= (a_l[W-1] == b_l[W-1]) && (s_y[N-1] != a_l[W-1]);
`endif
            state  <= DONE;
          end else begin
            idx    <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.y    = y_r;
  assign bus.cout = cout_r;
`ifdef RCA_SEQ_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed vectors, ignored start,
// back-to-back, randomized traffic against a transaction model, reset abort.
module tb_rca_seq_ctrl;

  localparam int N = 4;
  localparam int M = 4;
  localparam int W = N * M;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int passed = 0;

  // Transaction-level reference: cycles left in the current operation.
  int           rem      = 0;
  logic [W-1:0] lat_a    = '0;
  logic [W-1:0] lat_b    = '0;
  logic         lat_c    = 1'b0;
  logic [W:0]   exp_sum  = '0;
  logic         exp_ovf  = 1'b0;
  logic         exp_done = 1'b0;

  always #5 clk = ~clk;

  rca_seq_ctrl_if #(.N(N), .M(M)) bus ();

  rca_seq_ctrl #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    exp_done = 1'b0;
    if (rem == 0) begin
      if (bus.start) begin
        lat_a = bus.a;
        lat_b = bus.b;
        lat_c = bus.cin;
        rem   = M;
      end
    end else begin
      rem = rem - 1;
      if (rem == 0) begin
        exp_sum  = {1'b0, lat_a} + {1'b0, lat_b} + (W+1)'(lat_c);
        exp_ovf  = (lat_a[W-1] == lat_b[W-1]) && (exp_sum[W-1] != lat_a[W-1]);
        exp_done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_ctrl busy=%b done=%b required 0 0", bus.busy, bus.done);
    else passed++;
    checks++;
    if (bus.y !== '0 || bus.cout !== 1'b0) $display("FAIL reset_data y=%h cout=%b required 0000 0", bus.y, bus.cout);
    else passed++;
`ifdef RCA_SEQ_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) $display("FAIL reset_ovf ovf=%b required 0", bus.ovf);
    else passed++;
`endif
    bus.start = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_hold busy=%b required 0", bus.busy);
    else passed++;
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] av [5] = '{16'h0007, 16'h0007, 16'hFFFF, 16'h7FFF, 16'hFFFF};
    logic [W-1:0] bv [5] = '{16'h0005, 16'h000B, 16'h0001, 16'h0001, 16'hFFFF};
    logic         cv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] ey [5] = '{16'h000C, 16'h0013, 16'h0000, 16'h8000, 16'hFFFF};
    logic         ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.a     = av[i];
      bus.b     = bv[i];
      bus.cin   = cv[i];
      step();
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL dir%0d_busy busy=%b required 1", i, bus.busy);
      else passed++;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 4 * M) begin
        step();
        lat++;
      end
      checks++;
      if (lat !== M) $display("FAIL dir%0d_latency cycles=%0d required %0d", i, lat, M);
      else passed++;
      checks++;
      if (bus.y !== ey[i] || bus.cout !== ec[i] || bus.busy !== 1'b0)
        $display("FAIL dir%0d_sum y=%h cout=%b busy=%b required %h %b 0", i, bus.y, bus.cout, bus.busy, ey[i], ec[i]);
      else passed++;
`ifdef RCA_SEQ_OVF_EN
      checks++;
      if (bus.ovf !== eo[i]) $display("FAIL dir%0d_ovf ovf=%b required %b", i, bus.ovf, eo[i]);
      else passed++;
`else
      if (eo[i] === 1'bx) $display("dir%0d ovf reference undefined", i);
`endif
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.y !== ey[i] || bus.cout !== ec[i])
        $display("FAIL dir%0d_hold done=%b y=%h cout=%b required 0 %h %b", i, bus.done, bus.y, bus.cout, ey[i], ec[i]);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [W-1:0] y_at_done = '0;
    logic         c_at_done = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    step();
    bus.start = 1'b0;
    bus.a     = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.done === 1'b1) begin
        pulses++;
        y_at_done = bus.y;
        c_at_done = bus.cout;
      end
    end
    checks++;
    if (pulses !== 1) $display("FAIL ignore_pulses count=%0d required 1", pulses);
    else passed++;
    checks++;
    if (y_at_done !== 16'h3333 || c_at_done !== 1'b0)
      $display("FAIL ignore_sum y=%h cout=%b required 3333 0", y_at_done, c_at_done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int d1 = -1;
    int d2 = -1;
    rem = 0;
    for (int c = 0; c < 2 * M + 5; c++) begin
      bus.start = (c <= M + 1);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      model_edge();
      step();
      checks++;
      if (bus.done !== exp_done) $display("FAIL b2b_done cycle=%0d done=%b required %b", c, bus.done, exp_done);
      else passed++;
      if (exp_done) begin
        checks++;
        if (bus.y !== exp_sum[W-1:0] || bus.cout !== exp_sum[W])
          $display("FAIL b2b_sum y=%h cout=%b required %h %b", bus.y, bus.cout, exp_sum[W-1:0], exp_sum[W]);
        else passed++;
      end
      if (bus.done === 1'b1) begin
        pulses++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (pulses !== 2 || d2 - d1 !== M + 1)
      $display("FAIL b2b_spacing pulses=%0d gap=%0d required 2 %0d", pulses, d2 - d1, M + 1);
    else passed++;
  endtask

  task automatic test_random();
    logic have = 1'b0;
    rem = 0;
    for (int c = 0; c < 400; c++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      bus.b     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      bus.cin   = 1'($urandom);
      model_edge();
      step();
      if (exp_done) have = 1'b1;
      checks++;
      if (bus.busy !== (rem > 0) || bus.done !== exp_done)
        $display("FAIL rnd_ctrl cycle=%0d busy=%b done=%b required %b %b", c, bus.busy, bus.done, (rem > 0), exp_done);
      else passed++;
      if (have && rem == 0) begin
        checks++;
        if (bus.y !== exp_sum[W-1:0] || bus.cout !== exp_sum[W])
          $display("FAIL rnd_sum cycle=%0d y=%h cout=%b required %h %b", c, bus.y, bus.cout, exp_sum[W-1:0], exp_sum[W]);
        else passed++;
`ifdef RCA_SEQ_OVF_EN
        checks++;
        if (bus.ovf !== exp_ovf) $display("FAIL rnd_ovf cycle=%0d ovf=%b required %b", c, bus.ovf, exp_ovf);
        else passed++;
`endif
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < M + 1; c++) step();
  endtask

  task automatic test_reset_midrun();
    int pulses = 0;
    int lat;
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.y !== '0 || bus.cout !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midrun_reset y=%h cout=%b busy=%b done=%b required 0000 0 0 0", bus.y, bus.cout, bus.busy, bus.done);
    else passed++;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2 * M + 2; c++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL midrun_no_done active_cycles=%0d required 0", pulses);
    else passed++;
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h0007;
    bus.b     = 16'h0005;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL release_accept busy=%b required 1", bus.busy);
    else passed++;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 4 * M) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== M || bus.y !== 16'h000C || bus.cout !== 1'b0)
      $display("FAIL release_sum cycles=%0d y=%h cout=%b required %0d 000c 0", lat, bus.y, bus.cout, M);
    else passed++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
